dmem_bytelane: RTL and testbench
================================

DMEM_BYTELANE -- requirements
Module: dmem_bytelane

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words; power of two, 16..65536.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0; DEPTH*4-aligned.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  request accepted when req_valid && req_ready.
REQ-007 req_we  input  1  1 = store, 0 = load.
REQ-008 req_size  input  2  00 byte, 01 half, 10 word; 11 reserved.
REQ-009 req_uns  input  1  load zero-extend (lbu/lhu); ignored for stores and words.
REQ-010 req_addr  input  32  byte address.
REQ-011 req_wdata  input  32  store data, LSB-aligned (sb uses [7:0], sh uses [15:0]).
REQ-012 rsp_valid  output  1  response present.
REQ-013 rsp_ready  input  1  response consumed when rsp_valid && rsp_ready.
REQ-014 rsp_rdata  output  32  load data, extended; 0 for stores and errors.
REQ-015 rsp_err  output  1  access fault for this response.

Function
REQ-016 FSM states IDLE (no response held) and RESP (response held); req_ready = (state==IDLE) || rsp_ready.
REQ-017 Accepted request in cycle N yields rsp_valid in cycle N+1; exactly one response per accepted request, in order.
REQ-018 RESP holds rsp_rdata/rsp_err stable until handshake; rsp handshake with no new request -> IDLE; handshake with new request accepted same cycle -> stays RESP with new response.
REQ-019 Word index = (req_addr - BASE_ADDR)[log2(DEPTH)+1:2]; range fault when req_addr < BASE_ADDR or req_addr >= BASE_ADDR+DEPTH*4.
REQ-020 req_size==11 is a fault.
REQ-021 Store writes only byte lanes selected by size and addr[1:0] (sb: 1 lane, sh: 2 lanes, sw: 4); other lanes unchanged; write occurs in acceptance cycle.
REQ-022 Load returns selected lane(s) shifted to bit 0, sign-extended unless req_uns, read from memory state before any write in the same cycle.
REQ-023 Faulting access: no memory write, rsp_err=1, rsp_rdata=0.
REQ-024 Load immediately after store to the same word returns the stored data (write completes before the next read).
REQ-025 Memory contents are not initialised and not affected by rst.

Reset
REQ-026 rst forces state IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0; req_ready=1 in the cycle after reset deasserts.
REQ-027 rst mid-response discards the held response; a request presented in the rst cycle is not accepted and not written.

Configuration
REQ-028 Macro DMEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 is a fault (REQ-023).
REQ-029 DMEM_MISALIGN_TRAP_EN undefined: misaligned addresses are forced down to size alignment (half clears bit 0, word clears bits 1:0) and complete without fault.

Structure
REQ-030 Package dmem_pkg holds size encodings (SZ_B, SZ_H, SZ_W), FSM state typedef and the fault-check function.
REQ-031 Sub-module dmem_lane_align: combinational store byte-enable/data replication and load lane extract/extend; instantiated once.

Verification
REQ-032 sw 0xDEADBEEF @0x10, then lw @0x10 -> rsp_rdata=0xDEADBEEF, err=0, rsp one cycle after each accept.
REQ-033 After REQ-032: sb 0x5A @0x11, lb @0x11 -> 0x0000005A; lw @0x10 -> 0xDEAD5AEF; lb @0x13 -> 0xFFFFFFDE; lbu @0x13 -> 0x000000DE; lh @0x12 -> 0xFFFFDEAD.
REQ-034 rsp_ready held 0 for 3 cycles after load -> rsp_valid/rdata stable, req_ready=0; back-to-back loads with rsp_ready=1 -> one response per cycle.
REQ-035 DEPTH=256: sw @0x400 -> err=1, rdata=0, no word modified; size=11 -> err=1.
REQ-036 sh 0x1234 @0x21: macro defined -> err=1, memory unchanged; macro undefined -> lw @0x20 has [15:0]=0x1234.
REQ-037 rst asserted while rsp_valid=1 -> rsp_valid=0 next cycle; store presented during rst not written.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: access size encodings,
// response FSM state type and the access-fault / lane-alignment helpers.
package dmem_pkg;

   // Access size encodings as carried on req_size
   localparam logic [1:0] SZ_B   = 2'b00;
   localparam logic [1:0] SZ_H   = 2'b01;
   localparam logic [1:0] SZ_W   = 2'b10;
   localparam logic [1:0] SZ_RSV = 2'b11;

   // Response FSM: IDLE holds nothing, RESP holds one response
   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE = 1'b0;
   localparam state_t ST_RESP = 1'b1;

   // True when the low address bits do not match the natural size alignment
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] lo);
      return ((size == SZ_H) && lo[0]) || ((size == SZ_W) && (lo != 2'b00));
   endfunction

   // Lane offset after forcing the address down to size alignment
   function automatic logic [1:0] align_offset(input logic [1:0] size,
                                               input logic [1:0] lo);
      logic [1:0] off;
      case (size)
         SZ_H:    off = {lo[1], 1'b0};
         SZ_W:    off = 2'b00;
         default: off = lo;
      endcase
      return off;
   endfunction

   // Access fault: reserved size, address outside [base, base+span), or
   // misaligned when trapping is enabled. The limit is 33 bits wide so a
   // window ending exactly at 4 GiB does not wrap.
   function automatic logic access_fault(input logic [1:0]  size,
                                         input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [32:0] span,
                                         input logic        trap_en);
      logic [32:0] lim;
      logic        range_bad;
      lim       = {1'b0, base} + span;
      range_bad = (addr < base) || ({1'b0, addr} >= lim);
      return (size == SZ_RSV) || range_bad ||
             (trap_en && is_misaligned(size, addr[1:0]));
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store byte enables and data
// replication, plus load lane extraction with sign/zero extension.
// Purely combinational.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        uns,
   input  logic [1:0]  lane_off,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   output logic [31:0] rdata
);

   logic [31:0] shifted;

   // Bring the addressed lane down to bit 0 before extension
   assign shifted = rword >> {lane_off, 3'b000};

   // Select byte enables, replicate store data and extend load data by size
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      be        = 4'b0000;
      wdata_rep = wdata;
      rdata     = 32'h0;
      case (size)
         SZ_B: begin
            be        = 4'b0001 << lane_off;
            wdata_rep = {4{wdata[7:0]}};
            rdata     = {{24{~uns & shifted[7]}}, shifted[7:0]};
         end
         SZ_H: begin
            be        = lane_off[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
            rdata     = {{16{~uns & shifted[15]}}, shifted[15:0]};
         end
         SZ_W: begin
            be        = 4'b1111;
            wdata_rep = wdata;
            rdata     = rword;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_bytelane.sv
// Single-cycle data memory with byte-lane stores, sign/zero-extending loads
// and a one-deep valid/ready response buffer.
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned half/word
// accesses; otherwise misaligned addresses are forced down to size alignment.
module dmem_bytelane
   import dmem_pkg::*;
#(
   parameter int unsigned DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_uns,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW   = $clog2(DEPTH);
   localparam logic [32:0] SPAN = 33'(DEPTH) << 2;

`ifdef DMEM_MISALIGN_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   state_t        state;
   logic          accept;
   logic          fault;
   logic          wr_en;
   logic [AW-1:0] widx;
   logic [1:0]    lane_off;
   logic [31:0]   rword;
   logic [3:0]    be;
   logic [31:0]   wdata_rep;
   logic [31:0]   ld_data;
   logic [31:0]   mem [DEPTH];

   // A new request is taken whenever nothing is held or the held one drains now
   assign req_ready = (state == ST_IDLE) || rsp_ready;
   assign rsp_valid = (state == ST_RESP);
   assign accept    = req_valid && req_ready && !rst;

   // BASE_ADDR is window-aligned, so its low bits never borrow into the index
   assign widx     = req_addr[AW+1:2] - BASE_ADDR[AW+1:2];
   assign lane_off = align_offset(req_size, req_addr[1:0]);
   assign fault    = access_fault(req_size, req_addr, BASE_ADDR, SPAN, TRAP_EN);
   assign wr_en    = accept && req_we && !fault;

   // Read is asynchronous so the load sees the word before this cycle's write
   assign rword = mem[widx];

   dmem_lane_align u_align (
      .size      (req_size),
      .uns       (req_uns),
      .lane_off  (lane_off),
      .wdata     (req_wdata),
      .rword     (rword),
      .be        (be),
      .wdata_rep (wdata_rep),
      .rdata     (ld_data)
   );

   // Byte-lane write of the storage array in the acceptance cycle
   // NOTE: the array has no reset; its contents are undefined until written and survive rst.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int l = 0; l < 4; l++) begin
            if (be[l]) begin
               mem[widx][8*l +: 8] <= wdata_rep[8*l +: 8];
            end
         end
      end
   end

   // Response FSM and the held response registers
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
      if (rst) begin
         state     <= ST_IDLE;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else if (accept) begin
         state     <= ST_RESP;
         rsp_err   <= fault;
         rsp_rdata <= (fault || req_we) ? 32'h0 : ld_data;
      end else if (rsp_valid && rsp_ready) begin
         state <= ST_IDLE;
      end
   end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane: directed scenarios followed by
// random traffic, all compared against a byte-array reference model.
module tb_dmem_bytelane;

   localparam int unsigned DEPTH = 256;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam logic [63:0] LIM   = 64'(BASE) + 64'(DEPTH) * 64'd4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [1:0]  req_size;
   logic        req_uns;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   int tests = 0;
   int fails = 0;

   logic [7:0] mm [DEPTH*4];

   dmem_bytelane #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_size  (req_size),
      .req_uns   (req_uns),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: memory as bytes, access computed from size/address rules
   function automatic void model_access(input logic we, input logic [1:0] size,
                                        input logic uns, input logic [31:0] addr,
                                        input logic [31:0] wdata,
                                        output logic err, output logic [31:0] rdata);
      int          n;
      logic [31:0] a;
      err   = 1'b0;
      rdata = 32'h0;
      n     = 1 << size;
      if (size == 2'b11) err = 1'b1;
      if ({32'h0, addr} < 64'(BASE) || {32'h0, addr} >= LIM) err = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (size != 2'b11 && (addr % n) != 0) err = 1'b1;
`endif
      if (err) return;
      a = (addr - BASE) & ~32'(n - 1);
      if (we) begin
         for (int i = 0; i < n; i++) mm[int'(a) + i] = wdata[8*i +: 8];
      end else begin
         for (int i = 0; i < n; i++) rdata[8*i +: 8] = mm[int'(a) + i];
         if (!uns && n < 4 && rdata[8*n-1])
            rdata = rdata | ~((32'h1 << (8*n)) - 32'h1);
      end
   endfunction

   // One request, accepted at the next edge; response checked just after it
   task automatic xact(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input string tag);
      logic        e_err;
      logic [31:0] e_rd;
      model_access(we, size, uns, addr, wdata, e_err, e_rd);
      req_valid = 1'b1;
      req_we    = we;
      req_size  = size;
      req_uns   = uns;
      req_addr  = addr;
      req_wdata = wdata;
      @(posedge clk);
      #1;
      check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " rsp_err"},   32'(rsp_err),   32'(e_err));
      check({tag, " rsp_rdata"}, rsp_rdata,      e_rd);
   endtask

   task automatic idle();
      req_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0]  sz;
      logic [31:0] ad;
      int          r;

      rst       = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_size  = 2'b10;
      req_uns   = 1'b0;
      req_addr  = 32'h0;
      req_wdata = 32'h0;
      rsp_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst rsp_err",   32'(rsp_err),   32'd0);
      check("rst rsp_rdata", rsp_rdata,      32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post-rst req_ready", 32'(req_ready), 32'd1);

      // Give every word a known value
      for (int i = 0; i < int'(DEPTH); i++)
         xact(1'b1, 2'b10, 1'b0, BASE + 32'(i*4), $urandom, "fill");

      // Word store/load, then byte and half lanes
      xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, "sw 10");
      xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw 10");
      check("lw 10 lit", rsp_rdata, 32'hDEADBEEF);
      xact(1'b1, 2'b00, 1'b0, 32'h11, 32'hFFFFFF5A, "sb 11");
      xact(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, "lb 11");
      check("lb 11 lit", rsp_rdata, 32'h0000005A);
      xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "lw 10b");
      check("lw 10b lit", rsp_rdata, 32'hDEAD5AEF);
      xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, "lb 13");
      check("lb 13 lit", rsp_rdata, 32'hFFFFFFDE);
      xact(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, "lbu 13");
      check("lbu 13 lit", rsp_rdata, 32'h000000DE);
      xact(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, "lh 12");
      check("lh 12 lit", rsp_rdata, 32'hFFFFDEAD);

      // Range and reserved-size faults
      xact(1'b1, 2'b10, 1'b0, 32'h400, 32'h0BAD0BAD, "sw 400");
      check("sw 400 err lit",   32'(rsp_err), 32'd1);
      check("sw 400 rdata lit", rsp_rdata,    32'd0);
      xact(1'b0, 2'b11, 1'b0, 32'h20, 32'h0, "size11");
      check("size11 err lit", 32'(rsp_err), 32'd1);

      // Misaligned half store
      xact(1'b1, 2'b01, 1'b0, 32'h21, 32'h00001234, "sh 21");
`ifdef DMEM_MISALIGN_TRAP_EN
      check("sh 21 err lit", 32'(rsp_err), 32'd1);
      xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "lw 20");
`else
      check("sh 21 err lit", 32'(rsp_err), 32'd0);
      xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, "lw 20");
      check("lw 20 lo lit", {16'h0, rsp_rdata[15:0]}, 32'h00001234);
`endif
      idle();

      // Backpressure: response held stable, a pending store is not taken
      rsp_ready = 1'b0;
      xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "bp lw");
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b10;
      req_addr  = 32'h14;
      req_wdata = 32'h11111111;
      for (int c = 0; c < 3; c++) begin
         check("bp req_ready", 32'(req_ready), 32'd0);
         @(posedge clk);
         #1;
         check("bp rsp_valid", 32'(rsp_valid), 32'd1);
         check("bp rsp_rdata", rsp_rdata,      32'hDEAD5AEF);
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp drain valid", 32'(rsp_valid), 32'd0);
      xact(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, "lw 14");

      // Reset while a response is held; store in the reset cycle is dropped
      idle();
      rsp_ready = 1'b0;
      xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, "pre-rst lw");
      rst       = 1'b1;
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_size  = 2'b10;
      req_addr  = 32'h18;
      req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      #1;
      check("mid-rst rsp_valid", 32'(rsp_valid), 32'd0);
      check("mid-rst rsp_rdata", rsp_rdata,      32'd0);
      rst       = 1'b0;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      check("after-rst req_ready", 32'(req_ready), 32'd1);
      xact(1'b0, 2'b10, 1'b0, 32'h18, 32'h0, "lw 18");

      // Random traffic, mostly back-to-back
      for (int i = 0; i < 400; i++) begin
         r  = int'($urandom_range(0, 15));
         sz = (r == 0) ? 2'b11 : 2'(r % 3);
         case ($urandom_range(0, 9))
            0:       ad = 32'h400 + $urandom_range(0, 255);
            1:       ad = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: ad = BASE + 32'($urandom_range(0, DEPTH*4 - 1));
         endcase
         xact(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), ad, $urandom, "rand");
         if ($urandom_range(0, 7) == 0) idle();
      end

      // Whole-memory sweep against the model
      for (int i = 0; i < int'(DEPTH); i++)
         xact(1'b0, 2'b10, 1'b0, BASE + 32'(i*4), 32'h0, "sweep");
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
